// File: rtl/trisc_pkg.sv
// Shared definitions for the TRISC sequencer: opcodes, ALU selects,
// sequencer states and instruction field positions.
package trisc_pkg;

  // Opcodes held in instruction bits [9:7]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_LDI  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // ALU select codes; the ALU opcodes carry them directly in op[1:0]
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Instruction field positions
  localparam int INSTR_W = 10;
  localparam int OP_HI   = 9;
  localparam int OP_LO   = 7;
  localparam int RD_HI   = 6;
  localparam int RD_LO   = 5;
  localparam int RS_HI   = 4;
  localparam int RS_LO   = 3;
  localparam int RT_HI   = 2;
  localparam int RT_LO   = 1;
  localparam int IMM_HI  = 3;
  localparam int IMM_LO  = 0;
  localparam int TGT_HI  = 5;
  localparam int TGT_LO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // ALU-class instructions are exactly those with op[2] clear
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/trisc_regfile.sv
// 4-entry register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port.
module trisc_regfile #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  input  logic [1:0]        raddr_b,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_r [4];

  // Register storage: cleared on reset, single write port otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs_r[raddr_a];
  assign rdata_b  = regs_r[raddr_b];
  assign dbg_data = regs_r[dbg_sel];

endmodule

// File: rtl/trisc_ctrl.sv
// TRISC multi-cycle sequencer: fetches, decodes, drives the external ALU
// and writes results back into the register file.
module trisc_ctrl
  import trisc_pkg::*;
#(
  parameter int PC_W   = 6,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [9:0]        imem_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_s,
  input  logic [DATA_W-1:0] alu_r,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   pc
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t              state_r, state_nx_s;
  logic [PC_W-1:0]     pc_r;
  logic [INSTR_W-1:0]  instr_r;
  logic [DATA_W-1:0]   alu_a_r, alu_b_r, result_r;
  logic [1:0]          alu_s_r;
  logic [DATA_W-1:0]   rdata_a_s, rdata_b_s, wdata_s;
  logic                we_s;
  logic [2:0]          op_s;
  logic [1:0]          rd_s, rs_s, rt_s;
  logic [3:0]          imm_s;
  logic [5:0]          tgt_s;

  assign op_s  = instr_r[OP_HI:OP_LO];
  assign rd_s  = instr_r[RD_HI:RD_LO];
  assign rs_s  = instr_r[RS_HI:RS_LO];
  assign rt_s  = instr_r[RT_HI:RT_LO];
  assign imm_s = instr_r[IMM_HI:IMM_LO];
  assign tgt_s = instr_r[TGT_HI:TGT_LO];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state selection; start is only honoured from IDLE and HALT
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:   state_nx_s = start ? ST_FETCH : ST_IDLE;
      ST_FETCH:  state_nx_s = imem_valid ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (is_alu_op(op_s)) begin
          state_nx_s = ST_EXEC;
        end else if (op_s == OP_HALT) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_EXEC:   state_nx_s = ST_WB;
      ST_WB:     state_nx_s = ST_FETCH;
      ST_HALT:   state_nx_s = start ? ST_FETCH : ST_HALT;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Status and fetch-request outputs decoded from the state register
  always_comb begin
    imem_req = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
      end
      ST_DECODE, ST_EXEC, ST_WB: busy = 1'b1;
      ST_HALT:  halted = 1'b1;
      default:  halted = 1'b0;
    endcase
  end

  // Datapath: pc, instruction latch, ALU operand registers, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r     <= {PC_W{1'b0}};
      instr_r  <= {INSTR_W{1'b0}};
      alu_a_r  <= {DATA_W{1'b0}};
      alu_b_r  <= {DATA_W{1'b0}};
      alu_s_r  <= ALU_ADD;
      result_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            pc_r <= {PC_W{1'b0}};
          end
        end
        ST_FETCH: begin
          if (imem_valid) begin
            instr_r <= imem_data;
          end
        end
        ST_DECODE: begin
          case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
              alu_a_r <= rdata_a_s;
              alu_b_r <= rdata_b_s;
              alu_s_r <= op_s[1:0];
            end
            OP_LDI, OP_NOP: pc_r <= pc_r + PC_ONE;
            OP_JMP:         pc_r <= PC_W'(tgt_s);
            default:        pc_r <= pc_r;
          endcase
        end
        ST_EXEC: result_r <= alu_r;
        ST_WB:   pc_r <= pc_r + PC_ONE;
        default: pc_r <= pc_r;
      endcase
    end
  end

  // Register-file write: ALU result in WB, immediate in DECODE of LDI
  always_comb begin
    we_s    = 1'b0;
    wdata_s = result_r;
    if (state_r == ST_WB) begin
      we_s    = 1'b1;
      wdata_s = result_r;
    end else if ((state_r == ST_DECODE) && (op_s == OP_LDI)) begin
      we_s    = 1'b1;
      wdata_s = DATA_W'(imm_s);
    end else begin
      we_s    = 1'b0;
      wdata_s = result_r;
    end
  end

  trisc_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we_s),
    .waddr    (rd_s),
    .wdata    (wdata_s),
    .raddr_a  (rs_s),
    .raddr_b  (rt_s),
    .dbg_sel  (dbg_sel),
    .rdata_a  (rdata_a_s),
    .rdata_b  (rdata_b_s),
    .dbg_data (dbg_data)
  );

  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_s     = alu_s_r;

endmodule

// File: doc/trisc_ctrl.md
# trisc_ctrl

Multi-cycle instruction sequencer for the TRISC datapath. It drives the 4-bit ALU's operand and select inputs and collects its result. It fetches 10-bit instructions over a valid/request handshake, decodes them, and reads operands from an internal 4×4-bit register file. It issues operations to the external combinational ALU and writes the result back. It sits between instruction memory and the ALU as the only source of ALU operands and opcode.

## Interface
Parameters:
- PC_W, 6, program counter / instruction address width
- DATA_W, 4, register and ALU data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin execution at pc=0 (from IDLE or HALT)
- imem_req  out  1  fetch request, held until accepted
- imem_addr  out  PC_W  fetch address (= pc)
- imem_valid  in  1  imem_data valid; accepted when imem_req & imem_valid
- imem_data  in  10  instruction word
- alu_a  out  DATA_W  ALU operand A (registered)
- alu_b  out  DATA_W  ALU operand B (registered)
- alu_s  out  2  ALU select: 00 add, 01 sub, 10 and, 11 xor (registered)
- alu_r  in  DATA_W  ALU result
- dbg_sel  in  2  register-file debug read index
- dbg_data  out  DATA_W  combinational read of reg[dbg_sel]
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALT
- pc  out  PC_W  current program counter

## Operation
Instruction format: [9:7] op, [6:5] rd, [4:3] rs, [2:1] rt, [0] ignored. For LDI, imm = [3:0]. For JMP, target = [5:0].

Opcodes:
- 000 ADD
- 001 SUB
- 010 AND
- 011 XOR
- 100 LDI (rd ← imm)
- 101 JMP (pc ← target)
- 110 NOP
- 111 HALT

States and transitions:
- IDLE: outputs quiet. On start → FETCH with pc=0.
- FETCH: imem_req=1, imem_addr=pc. On acceptance, latch instr → DECODE.
- DECODE:
  - ALU ops: alu_a←reg[rs], alu_b←reg[rt], alu_s←op[1:0] → EXEC.
  - LDI: write rd, pc+1 → FETCH.
  - JMP: pc←target → FETCH.
  - NOP: pc+1 → FETCH.
  - HALT: pc unchanged → HALT.
- EXEC: alu_a/alu_b/alu_s held stable. alu_r captured at end of cycle → WB.
- WB: reg[rd]←captured result, pc+1 → FETCH.
- HALT: halted=1. On start → FETCH with pc=0. Registers retained.

Rules:
- Arithmetic is 4-bit modulo. The ALU's carry and overflow are not consumed.
- pc increment wraps 63→0.
- alu_a/alu_b/alu_s change only in DECODE. They hold their last value in every other state.
- start is ignored while busy.

## Timing
- Reset (async, rst_n=0): state=IDLE, pc=0, all registers=0, alu_a=alu_b=0, alu_s=00, imem_req=0, busy=0, halted=0.
- Reset mid-instruction aborts immediately. No partial writeback is performed.
- With zero-wait memory (imem_valid high in the same cycle as imem_req):
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB)
  - LDI, NOP, JMP: 2 cycles
  - HALT: 2 cycles to halted=1
- Each imem_valid low cycle in FETCH adds one cycle. imem_req stays high and imem_addr stays stable meanwhile.
- The register-file write is visible on dbg_data the cycle after WB (or after DECODE for LDI).
- rd == rs or rd == rt is legal. Operands are read in DECODE, before writeback.

## Structure
- Shared package trisc_pkg holds:
  - opcode constants (OP_ADD … OP_HALT)
  - ALU select constants (ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_XOR=11)
  - state enum
  - instruction field bit positions
- One sub-module: trisc_regfile (4×DATA_W, one synchronous write port, two combinational read ports plus a debug port).
- The sequencer FSM and pc live in trisc_ctrl.

## Test plan
- Reset, then start; program LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT → r3=8, halted=1 after 2+2+4+2=10 cycles.
- Program LDI r1,2; LDI r2,3; SUB r0,r1,r2 → r0=4'hF. AND/XOR with r1=4'hC, r2=4'hA → 4'h8 and 4'h6. alu_s observed 01/10/11 respectively.
- Hold imem_valid low 3 cycles during the second fetch → imem_req and imem_addr stable throughout. Total program time grows by exactly 3 cycles.
- JMP to 63 with NOP at 63 → pc wraps to 0 and re-executes the instruction at address 0.
- Assert rst_n=0 during EXEC of ADD r3 → r3 stays 0, state IDLE, all outputs at reset values. A later start reruns the program from pc=0.
- ADD r1,r1,r1 with r1=9 → r1=2 (modulo 16). start pulsed while busy has no effect. start in HALT restarts at pc=0 with registers retained.
